sync_cdc_tx: RTL

Single-clock write-side sender for the MSB-valid CDC word format: `{valid, payload}` with the valid flag in bit WIDTH-1. It accepts a ready/valid stream, buffers it, and emits one `{1, payload}` word per cycle only while downstream credits remain, so the read-side CDC FIFO can never overflow. It sits in the `wr_clk` domain directly in front of the CDC synchronizer. Credits come back as already-synchronized single-cycle pulses, one per word the read side consumed.

---
 rtl/sync_cdc_tx.sv | 127 ++++++++++++
 1 files changed

// File: rtl/sync_cdc_tx.sv
// ----------------------------------------------------------------------------
// sync_cdc_tx
//
// Write-side sender for the MSB-valid CDC word format {valid, payload}.
// Accepts a ready/valid stream into a small circular buffer. It emits one
// {1, payload} word per cycle, but only while downstream credits remain, so
// the read-side CDC FIFO can never overflow. Idle cycles emit all zeros.
//
// Ports:
//   wr_clk        sole clock
//   rst_n         asynchronous active-low reset
//   s_data        payload to send (WIDTH-1 bits)
//   s_valid       s_data valid
//   s_ready       buffer can accept (combinational from registered state)
//   credit_ret    single-cycle pulse returning one downstream credit
//   cdc_word_out  registered {valid, payload} word to the CDC synchronizer
//   credits_avail registered count of credits currently held
//   buf_count     local buffer occupancy
//   credit_err    sticky flag: a credit came back while already holding all
// ----------------------------------------------------------------------------
module sync_cdc_tx #(
    parameter int WIDTH   = 193,
    parameter int DEPTH   = 4,
    parameter int CREDITS = 16,
    parameter int CW      = $clog2(CREDITS + 1)
) (
    input  logic                       wr_clk,
    input  logic                       rst_n,
    input  logic [WIDTH-2:0]           s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic                       credit_ret,
    output logic [WIDTH-1:0]           cdc_word_out,
    output logic [CW-1:0]              credits_avail,
    output logic [$clog2(DEPTH+1)-1:0] buf_count,
    output logic                       credit_err
);

    localparam int PW = WIDTH - 1;
    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(DEPTH + 1);

    logic [PW-1:0]    r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [BW-1:0]    r_count;
    logic [CW-1:0]    r_credits;
    logic [WIDTH-1:0] r_word;
    logic             r_err;

    logic             w_push;
    logic             w_send;
    logic             w_full_credits;

    // Readiness is gated by rst_n so nothing is accepted while held in reset.
    assign s_ready        = (r_count < BW'(DEPTH)) & rst_n;
    assign w_push         = s_valid & s_ready;
    // A send needs both a buffered word and a credit, so the credit
    // decrement below can never underflow.
    assign w_send         = (r_count != '0) & (r_credits != '0);
    assign w_full_credits = (r_credits == CW'(CREDITS));

    // Payload storage carries no reset: occupancy and pointers decide what
    // is meaningful, so stale contents are never emitted.
    always_ff @(posedge wr_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_send) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_send})
                2'b10:   r_count <= r_count + BW'(1);
                2'b01:   r_count <= r_count - BW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Output word register: head of buffer with valid set on a send,
    // otherwise an all-zero idle word.
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= '0;
        end else if (w_send) begin
            r_word <= {1'b1, r_mem[r_rd_ptr]};
        end else begin
            r_word <= '0;
        end
    end

    // Credit counter: minus one per send, plus one per returned credit.
    // A return while already full saturates and raises the sticky error.
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credits <= CW'(CREDITS);
            r_err     <= 1'b0;
        end else begin
            case ({w_send, credit_ret})
                2'b10:   r_credits <= r_credits - CW'(1);
                2'b01:   if (!w_full_credits) r_credits <= r_credits + CW'(1);
                default: r_credits <= r_credits;
            endcase
            if (credit_ret && w_full_credits) begin
                r_err <= 1'b1;
            end
        end
    end

    assign cdc_word_out  = r_word;
    assign credits_avail = r_credits;
    assign buf_count     = r_count;
    assign credit_err    = r_err;

endmodule
